// File: rtl/result_pkg.sv
// result_pkg: shared defaults and the stored entry layout for result_fifo.
package result_pkg;
   localparam int DATA_W  = 16;
   localparam int DEPTH   = 4;
   localparam int VEC_LEN = 3;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } entry_t;
endpackage

// File: rtl/result_fifo_if.sv
// result_fifo_if: handshake bundle between the upstream datapath, the FIFO and its consumer.
interface result_fifo_if #(
   parameter int DATA_W = result_pkg::DATA_W,
   parameter int DEPTH  = result_pkg::DEPTH
);
   logic [DATA_W-1:0]      in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic                   flush;
   logic [DATA_W-1:0]      out_data;
   logic                   out_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] count;
   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_data, out_last, out_valid, count
   );
   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_data, out_last, out_valid, count
   );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up counter with synchronous clear; wrap is high at the terminal value N-1.
module mod_counter #(
   parameter  int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] value,
   output logic         wrap
);
   logic [W-1:0] r_value;
   assign value = r_value;
   assign wrap  = r_value == W'(N - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) r_value <= '0;
      else if (clr) r_value <= '0;
      else if (en) r_value <= wrap ? '0 : r_value + 1'b1;
endmodule

// File: rtl/result_fifo.sv
// result_fifo: flop-array FIFO for accumulator results that tags the final element of each vector.
// Occupancy comes from pointer difference, with one phase bit per pointer toggled on each wrap.
module result_fifo #(
   parameter int DATA_W  = result_pkg::DATA_W,
   parameter int DEPTH   = result_pkg::DEPTH,
   parameter int VEC_LEN = result_pkg::VEC_LEN
) (
   input logic          clk,
   input logic          rst,
   result_fifo_if.slave bus
);
   import result_pkg::*;
   localparam int AW = $clog2(DEPTH);
   localparam int VW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   entry_t        r_mem [DEPTH];
   logic [AW-1:0] w_rd_ptr, w_wr_ptr;
   logic          w_rd_wrap, w_wr_wrap, w_vpos_wrap;
   logic [VW-1:0] w_vpos_unused;
   logic          r_rd_phase, r_wr_phase;
   logic          w_push, w_pop;
   assign w_push        = bus.in_valid & bus.in_ready & ~bus.flush;
   assign w_pop         = bus.out_valid & bus.out_ready & ~bus.flush;
   assign bus.count     = {r_wr_phase, w_wr_ptr} - {r_rd_phase, w_rd_ptr};
   assign bus.in_ready  = bus.count != (AW + 1)'(DEPTH);
   assign bus.out_valid = bus.count != '0;
   assign bus.out_data  = r_mem[w_rd_ptr].data;
   assign bus.out_last  = bus.out_valid & r_mem[w_rd_ptr].last;
   mod_counter #(.N(DEPTH)) u_rd_ptr (
      .clk(clk), .rst(rst), .clr(bus.flush), .en(w_pop), .value(w_rd_ptr), .wrap(w_rd_wrap)
   );
   mod_counter #(.N(DEPTH)) u_wr_ptr (
      .clk(clk), .rst(rst), .clr(bus.flush), .en(w_push), .value(w_wr_ptr), .wrap(w_wr_wrap)
   );
   mod_counter #(.N(VEC_LEN)) u_vpos (
      .clk(clk), .rst(rst), .clr(bus.flush), .en(w_push), .value(w_vpos_unused), .wrap(w_vpos_wrap)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_rd_phase <= 1'b0;
         r_wr_phase <= 1'b0;
      end else if (bus.flush) begin
         r_rd_phase <= 1'b0;
         r_wr_phase <= 1'b0;
      end else begin
         if (w_pop && w_rd_wrap) r_rd_phase <= ~r_rd_phase;
         if (w_push && w_wr_wrap) r_wr_phase <= ~r_wr_phase;
      end
   // storage is deliberately left unreset; out_last is gated so stale bits never leak
   always_ff @(posedge clk)
      if (w_push) r_mem[w_wr_ptr] <= '{data: bus.in_data, last: w_vpos_wrap};
endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: directed tables, hand sequences and random traffic against a queue-based model.
module tb_result_fifo;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   result_fifo_if bus ();
   result_fifo dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } ent_t;
   typedef struct {
      logic        iv;
      logic [15:0] d;
      logic        ordy;
      logic        fl;
      int          cnt;
      logic        ov;
      logic [15:0] od;
      logic        ol;
      logic        ir;
   } vec_t;
   ent_t q[$];
   int   vpos = 0;
   int   checks = 0;
   int   failures = 0;
   vec_t tbl[6];
   function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", n, a, e, $time);
      end
   endfunction
   function automatic void model_edge(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
      int n = q.size();
      if (fl) begin
         q.delete();
         vpos = 0;
      end else begin
         if (ordy && n != 0) void'(q.pop_front());
         if (iv && n != 4) begin
            q.push_back('{data: d, last: (vpos == 2)});
            vpos = (vpos + 1) % 3;
         end
      end
   endfunction
   function automatic void chk_model();
      chk("m_in_ready", bus.in_ready, q.size() != 4);
      chk("m_out_valid", bus.out_valid, q.size() != 0);
      chk("m_count", bus.count, q.size());
      if (q.size() != 0) begin
         chk("m_out_data", bus.out_data, q[0].data);
         chk("m_out_last", bus.out_last, q[0].last);
      end else chk("m_out_last_empty", bus.out_last, 0);
   endfunction
   task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      bus.flush     = fl;
      @(posedge clk);
      model_edge(iv, d, ordy, fl);
      @(negedge clk);
      chk_model();
   endtask
   initial begin
      tbl[0] = '{1'b1, 16'd10, 1'b0, 1'b0, 1, 1'b1, 16'd10, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 16'd20, 1'b0, 1'b0, 2, 1'b1, 16'd10, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 16'd30, 1'b0, 1'b0, 3, 1'b1, 16'd10, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 16'd0,  1'b1, 1'b0, 2, 1'b1, 16'd20, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 16'd0,  1'b1, 1'b0, 1, 1'b1, 16'd30, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 16'd0,  1'b1, 1'b0, 0, 1'b0, 16'd0,  1'b0, 1'b1};
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_count", bus.count, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         chk($sformatf("tbl%0d_count", i), bus.count, tbl[i].cnt);
         chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].ov);
         chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].ir);
         chk($sformatf("tbl%0d_out_last", i), bus.out_last, tbl[i].ol);
         if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].od);
      end
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(100 + i), 1'b0, 1'b0);
      chk("full_in_ready", bus.in_ready, 0);
      cyc(1'b1, 16'd55, 1'b0, 1'b0);
      chk("held_count", bus.count, 4);
      cyc(1'b1, 16'd55, 1'b1, 1'b0);
      chk("pop_at_full_count", bus.count, 3);
      cyc(1'b1, 16'd55, 1'b0, 1'b0);
      chk("held_accepted_count", bus.count, 4);
      for (int i = 0; i < 3; i++) cyc(1'b0, 16'd0, 1'b1, 1'b0);
      chk("held_data", bus.out_data, 16'd55);
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      chk("drained", bus.out_valid, 0);
      cyc(1'b0, 16'd0, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 16'(200 + i), 1'b1, 1'b0);
         chk("stream_valid", bus.out_valid, 1);
         chk("stream_count", bus.count, 1);
         chk("stream_data", bus.out_data, 200 + i);
         chk("stream_last", bus.out_last, (i % 3) == 0);
      end
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      cyc(1'b1, 16'd1, 1'b0, 1'b1);
      cyc(1'b1, 16'd1, 1'b0, 1'b0);
      cyc(1'b1, 16'd2, 1'b0, 1'b0);
      chk("pre_flush_count", bus.count, 2);
      cyc(1'b1, 16'd3, 1'b1, 1'b1);
      chk("flush_count", bus.count, 0);
      chk("flush_out_valid", bus.out_valid, 0);
      cyc(1'b1, 16'd4, 1'b0, 1'b0);
      chk("flush_first_last", bus.out_last, 0);
      cyc(1'b1, 16'd5, 1'b0, 1'b0);
      cyc(1'b1, 16'd6, 1'b0, 1'b0);
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      chk("flush_vpos_data", bus.out_data, 16'd6);
      chk("flush_vpos_last", bus.out_last, 1);
      cyc(1'b0, 16'd0, 1'b1, 1'b0);
      cyc(1'b1, 16'd7, 1'b0, 1'b0);
      cyc(1'b1, 16'd8, 1'b0, 1'b0);
      cyc(1'b1, 16'd9, 1'b0, 1'b0);
      chk("pre_rst_count", bus.count, 3);
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_in_ready", bus.in_ready, 1);
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_count", bus.count, 0);
      q.delete();
      vpos = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(300 + i), 1'b0, 1'b0);
      chk("post_rst_last", bus.out_last, 0);
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
